inst_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end placed between the MIPS core and the instruction memory in the SOC top level. It generates sequential fetch addresses itself and drives the memory chip-enable and address. It tolerates a fixed multi-cycle memory read latency and buffers returned instructions in a DEPTH-entry FIFO. The core consumes instructions via a valid/ready handshake and can redirect the fetch stream (branch/jump/exception) with a single-cycle flush.

---
 rtl/inst_prefetch_queue.sv | 190 +++++++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction fetch front end.
// Issues reads to a fixed-latency instruction memory and buffers the words
// in a DEPTH-entry FIFO. The core drains the FIFO through a valid/ready
// handshake. A single-cycle redirect flushes everything and restarts fetch.
// Issue is credit-limited so that a returning word always finds a free slot.
// Optional feature macro: FETCH_PERF_EN adds the fetch_cnt/stall_cnt counters.
module inst_prefetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;  // holds 0..DEPTH
  localparam int LAT_W = 3;                  // holds 0..MEM_LAT (MEM_LAT <= 4)
  localparam int SUM_W = CNT_W + 2;          // holds fifo + in-flight total

  // Fetch address and FIFO occupancy
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [CNT_W-1:0]  r_count;

  // FIFO storage as a shift queue: entry 0 is always the head, so the
  // head outputs come straight from registers.
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];

  // In-flight tracker: stage k holds the read issued k+1 cycles ago
  logic              r_trk_v  [MEM_LAT];
  logic [ADDR_W-1:0] r_trk_pc [MEM_LAT];

  logic              w_pop;
  logic              w_ret;
  logic              w_credit;
  logic              w_issue;
  logic [LAT_W-1:0]  w_inflight;
  logic [CNT_W-1:0]  w_wr_idx;

  // Count of reads still outstanding in the memory pipeline
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      w_inflight = w_inflight + {{(LAT_W-1){1'b0}}, r_trk_v[i]};
    end
  end

  // A pop in the same cycle is deliberately not credited: the returning word
  // of a read issued now must fit even if the core stops draining.
  assign w_credit = ({2'b00, r_count} + {{(SUM_W-LAT_W){1'b0}}, w_inflight})
                    < SUM_W'(DEPTH);
  assign w_issue  = !rst && !redirect && w_credit;

  // Redirect wins over a coincident pop
  assign w_pop    = inst_valid && inst_ready && !redirect;
  assign w_ret    = r_trk_v[MEM_LAT-1];

  // Returning word lands behind the entries that survive this cycle's pop
  assign w_wr_idx = r_count - {{(CNT_W-1){1'b0}}, w_pop};

  assign mem_ce     = w_issue;
  assign mem_addr   = rst ? RESET_PC : r_fetch_pc;
  assign inst_valid = (r_count != '0);
  assign inst_data  = r_q_data[0];
  assign inst_pc    = r_q_pc[0];

  // Fetch address: reset, redirect, or advance after each issue (wraps)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
    end
  end

  // FIFO occupancy: flush on reset/redirect, otherwise +return -pop
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, w_ret} - {{(CNT_W-1){1'b0}}, w_pop};
    end
  end

  genvar gi;

  // In-flight tracker stages
  generate
    for (gi = 0; gi < MEM_LAT; gi++) begin : g_trk
      if (gi == 0) begin : g_first
        // First stage captures the read issued this cycle
        always_ff @(posedge clk) begin
          if (rst || redirect) begin
            r_trk_v[gi]  <= 1'b0;
            r_trk_pc[gi] <= '0;
          end else begin
            r_trk_v[gi]  <= w_issue;
            r_trk_pc[gi] <= r_fetch_pc;
          end
        end
      end else begin : g_next
        // Later stages age the outstanding reads by one cycle
        always_ff @(posedge clk) begin
          if (rst || redirect) begin
            r_trk_v[gi]  <= 1'b0;
            r_trk_pc[gi] <= '0;
          end else begin
            r_trk_v[gi]  <= r_trk_v[gi-1];
            r_trk_pc[gi] <= r_trk_pc[gi-1];
          end
        end
      end
    end
  endgenerate

  // FIFO entries: write the returning word, else shift toward the head on pop
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_q
      logic [DATA_W-1:0] w_shift_data;
      logic [ADDR_W-1:0] w_shift_pc;

      if (gi == DEPTH - 1) begin : g_tail
        assign w_shift_data = '0;
        assign w_shift_pc   = '0;
      end else begin : g_body
        assign w_shift_data = r_q_data[gi+1];
        assign w_shift_pc   = r_q_pc[gi+1];
      end

      // One FIFO slot; a redirect leaves contents untouched since count is cleared
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q_data[gi] <= '0;
          r_q_pc[gi]   <= '0;
        end else if (!redirect) begin
          if (w_ret && (w_wr_idx == CNT_W'(gi))) begin
            r_q_data[gi] <= mem_data;
            r_q_pc[gi]   <= r_trk_pc[MEM_LAT-1];
          end else if (w_pop) begin
            r_q_data[gi] <= w_shift_data;
            r_q_pc[gi]   <= w_shift_pc;
          end
        end
      end
    end
  endgenerate

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating issue and starvation counters; survive redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_issue && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (inst_ready && !inst_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue. A queue-based reference model
// (FIFO contents plus outstanding reads with their return cycle) predicts
// every cycle's outputs; directed steps add latency and boundary checks.
module tb_inst_prefetch_queue;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam int          MEM_LAT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          PC_STEP  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              mem_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
`ifdef FETCH_PERF_EN
  logic [31:0]       fetch_cnt;
  logic [31:0]       stall_cnt;
`endif

  inst_prefetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT),
    .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)
  ) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_data(mem_data)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] pc; int ret; } fl_t;

  ent_t        mq[$];       // expected FIFO contents, head first
  fl_t         mf[$];       // outstanding reads, oldest first
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  logic        h_ce   [8];  // memory-side history of issued requests
  logic [31:0] h_addr [8];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  bit last_ce;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive memory data, compare against model, advance model.
  // Entered and left at posedge+1 with rst/redirect/inst_ready already set.
  task automatic cycle();
    bit          e_ce;
    bit          e_v;
    logic [31:0] e_addr;
    ent_t        e;
    fl_t         f;
    int          k;
    k = (cyc - MEM_LAT) & 7;
    if (cyc >= MEM_LAT && h_ce[k] === 1'b1) mem_data = memfn(h_addr[k]);
    else mem_data = $urandom();
    #1;
    e_ce   = !rst && !redirect && ((mq.size() + mf.size()) < DEPTH);
    e_addr = rst ? RESET_PC : m_pc;
    e_v    = (mq.size() != 0);
    if (chk_en) begin
      chk("mem_ce", 64'(mem_ce), 64'(e_ce));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("inst_valid", 64'(inst_valid), 64'(e_v));
      if (e_v) begin
        chk("inst_pc", 64'(inst_pc), 64'(mq[0].pc));
        chk("inst_data", 64'(inst_data), 64'(mq[0].data));
      end
`ifdef FETCH_PERF_EN
      chk("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end
    last_ce = mem_ce;
    h_ce[cyc & 7]   = mem_ce;
    h_addr[cyc & 7] = mem_addr;
    if (rst) begin
      mq.delete(); mf.delete();
      m_pc = RESET_PC; m_fetch = 0; m_stall = 0;
    end else begin
      if (e_ce && m_fetch != 32'hFFFF_FFFF) m_fetch++;
      if (inst_ready && !e_v && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (redirect) begin
        mq.delete(); mf.delete();
        m_pc = redirect_pc;
      end else begin
        if (e_v && inst_ready) begin
          $display("pop  pc=%08h data=%08h cyc=%0d", mq[0].pc, mq[0].data, cyc);
          void'(mq.pop_front());
        end
        if (mf.size() != 0 && mf[0].ret == cyc) begin
          e.pc = mf[0].pc; e.data = memfn(mf[0].pc);
          mq.push_back(e);
          void'(mf.pop_front());
        end
        if (e_ce) begin
          f.pc = m_pc; f.ret = cyc + MEM_LAT;
          mf.push_back(f);
          m_pc = m_pc + PC_STEP;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int first;
    int issues;
    for (int i = 0; i < 8; i++) begin h_ce[i] = 1'b0; h_addr[i] = '0; end
    m_pc = RESET_PC; m_fetch = 0; m_stall = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1; mem_data = '0;
    @(posedge clk); #1;

    // Step 1: reset, then release with inst_ready high
    cycle();
    chk_en = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    #1;
    chk("rst_inst_valid", 64'(inst_valid), 64'(0));
    chk("rst_inst_pc", 64'(inst_pc), 64'(0));
    chk("rst_inst_data", 64'(inst_data), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(RESET_PC));
    first = -1;
    for (int i = 0; i < 16; i++) begin
      if (first < 0 && inst_valid) first = i;
      cycle();
    end
    chk("first_valid_cycle", 64'(first), 64'(MEM_LAT + 1));

    // Step 2: fill with inst_ready low; exactly DEPTH issues then stall
    rst = 1'b1; cycle(); rst = 1'b0;
    inst_ready = 1'b0;
    issues = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      issues += int'(last_ce);
    end
    chk("fill_issue_count", 64'(issues), 64'(DEPTH));
    chk("fill_head_pc", 64'(inst_pc), 64'(RESET_PC));
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    // Step 3: redirect with reads in flight; stale words must never appear
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      if (first < 0 && inst_valid) begin
        first = i;
        chk("redir_pc", 64'(inst_pc), 64'(32'h0000_0100));
        chk("redir_data", 64'(inst_data), 64'(memfn(32'h0000_0100)));
      end
      cycle();
    end
    chk("redir_latency", 64'(first), 64'(MEM_LAT + 1));

    // Step 4: redirect coincident with a pop of a valid head
    chk("pre_redir_valid", 64'(inst_valid), 64'(1));
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cycle();
    redirect = 1'b0;
    chk("post_redir_empty", 64'(inst_valid), 64'(0));
    chk("post_redir_fetch_pc", 64'(mem_addr), 64'(32'h0000_0200));
    for (int i = 0; i < 6; i++) cycle();

    // Step 5: reset mid-stream with a full FIFO
    inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    chk("full_before_rst", 64'(inst_valid), 64'(1));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(inst_valid), 64'(0));
    chk("mid_rst_pc", 64'(inst_pc), 64'(0));
    chk("mid_rst_data", 64'(inst_data), 64'(0));
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'(RESET_PC));
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    // Step 6: random traffic, redirects (including near the wrap point) and resets
    for (int i = 0; i < 500; i++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      redirect   = ($urandom_range(0, 19) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF8;
      else redirect_pc = $urandom() & 32'hFFFF_FFFC;
      cycle();
    end
    rst = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
